// File: rtl/pipe_pkg.sv
// pipe_pkg: forwarding select codes and the ID/EX control-field layout
package pipe_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam int CTRL_W         = 8;
  localparam int CTRL_REG_WRITE = 7;
  localparam int CTRL_MEM_READ  = 6;
  localparam int CTRL_MEM_WRITE = 5;
  localparam int CTRL_ALU_SRC   = 4;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [3:0] alu_op;
  } ctrl_t;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: operand select, WB bypass and load-use/RAW stall detection.
// ID_EX_FWD_EN enables EX/MEM and MEM/WB forwarding; otherwise every RAW stalls.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic            id_valid_i,
  input  logic [REGW-1:0] id_rs1_i,
  input  logic [REGW-1:0] id_rs2_i,
  input  logic            ex_valid_i,
  input  logic            ex_reg_write_i,
  input  logic            ex_mem_read_i,
  input  logic [REGW-1:0] ex_rd_i,
  input  logic [REGW-1:0] mem_rd_i,
  input  logic            mem_reg_write_i,
  input  logic [REGW-1:0] wb_rd_i,
  input  logic            wb_reg_write_i,
  input  logic            flush_i,
  output logic [1:0]      fwd_a_o,
  output logic [1:0]      fwd_b_o,
  output logic            byp_a_o,
  output logic            byp_b_o,
  output logic            hazard_o,
  output logic            stall_o
);
  logic ex_w, ex_ld, mem_w, wb_w;
  logic ex_a, ex_b, mem_a, mem_b;
  assign ex_w  = ex_valid_i & ex_reg_write_i & (|ex_rd_i);
  assign ex_ld = ex_valid_i & ex_mem_read_i & (|ex_rd_i);
  assign mem_w = mem_reg_write_i & (|mem_rd_i);
  assign wb_w  = wb_reg_write_i & (|wb_rd_i);
  assign ex_a  = ex_rd_i == id_rs1_i;
  assign ex_b  = ex_rd_i == id_rs2_i;
  assign mem_a = mem_rd_i == id_rs1_i;
  assign mem_b = mem_rd_i == id_rs2_i;
  assign byp_a_o = wb_w & (wb_rd_i == id_rs1_i);
  assign byp_b_o = wb_w & (wb_rd_i == id_rs2_i);
`ifdef ID_EX_FWD_EN
  assign fwd_a_o  = (ex_w & ex_a) ? FWD_MEM : (mem_w & mem_a) ? FWD_WB : FWD_RF;
  assign fwd_b_o  = (ex_w & ex_b) ? FWD_MEM : (mem_w & mem_b) ? FWD_WB : FWD_RF;
  assign hazard_o = id_valid_i & ex_ld & (ex_a | ex_b);
`else
  assign fwd_a_o  = FWD_RF;
  assign fwd_b_o  = FWD_RF;
  assign hazard_o = id_valid_i & (((ex_w | ex_ld) & (ex_a | ex_b)) | (mem_w & (mem_a | mem_b)));
`endif
  assign stall_o = hazard_o & ~flush_i;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with hazard detection and registered forward selects.
// Define ID_EX_FWD_EN to enable operand forwarding; default build stalls on every RAW.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  ctrl_t           id_ctrl,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic [REGW-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            stall_o,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [REGW-1:0] ex_rs1,
  output logic [REGW-1:0] ex_rs2,
  output logic [REGW-1:0] ex_rd,
  output ctrl_t           ex_ctrl,
  output logic [1:0]      ex_fwd_a,
  output logic [1:0]      ex_fwd_b
);
  localparam int W = 1 + 4 * XLEN + 3 * REGW + CTRL_W + 4;
  logic [1:0]   fwd_a, fwd_b;
  logic         byp_a, byp_b, hazard;
  logic [W-1:0] stage_d, stage_q;
  fwd_unit #(.REGW(REGW)) u_fwd (
    .id_valid_i      (id_valid),
    .id_rs1_i        (id_rs1),
    .id_rs2_i        (id_rs2),
    .ex_valid_i      (ex_valid),
    .ex_reg_write_i  (ex_ctrl[CTRL_REG_WRITE]),
    .ex_mem_read_i   (ex_ctrl[CTRL_MEM_READ]),
    .ex_rd_i         (ex_rd),
    .mem_rd_i        (mem_rd),
    .mem_reg_write_i (mem_reg_write),
    .wb_rd_i         (wb_rd),
    .wb_reg_write_i  (wb_reg_write),
    .flush_i         (flush),
    .fwd_a_o         (fwd_a),
    .fwd_b_o         (fwd_b),
    .byp_a_o         (byp_a),
    .byp_b_o         (byp_b),
    .hazard_o        (hazard),
    .stall_o         (stall_o)
  );
  // Bubbles load all-zero so the EX stage sees a harmless nop with select 00.
  assign stage_d = (flush | hazard) ? '0 :
                   {id_valid, id_pc, byp_a ? wb_data : id_rs1_data, byp_b ? wb_data : id_rs2_data,
                    id_imm, id_rs1, id_rs2, id_rd, id_ctrl, fwd_a, fwd_b};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end
  assign {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
          ex_ctrl, ex_fwd_a, ex_fwd_b} = stage_q;
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection and registered forwarding-select generation. Captures decoded operands and control from ID, emits them to EX one cycle later together with the 2-bit select codes that drive the EX operand three-way muxes. Sits between the decode stage and the EX operand muxes; drives the IF/ID stall line.

## Interface

Parameters:
- XLEN, 32, datapath width
- REGW, 5, register-index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  decoded immediate
- id_rs1, id_rs2, id_rd  in  REGW  register indices
- id_ctrl  in  8  {reg_write, mem_read, mem_write, alu_src, alu_op[3:0]}
- mem_rd  in  REGW  rd currently in EX/MEM
- mem_reg_write  in  1  EX/MEM writes rd
- wb_rd  in  REGW  rd being written back this cycle
- wb_reg_write  in  1  MEM/WB writes rd
- wb_data  in  XLEN  write-back data
- flush  in  1  taken branch/jump resolved in EX
- stall_o  out  1  freeze PC and IF/ID (combinational)
- ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl  out  widths as ID counterparts  registered ID/EX contents
- ex_fwd_a, ex_fwd_b  out  2  select for operand A/B mux

## Operation

- Select encoding: 00 = ex_rsN_data (register file), 01 = MEM/WB result, 1x = EX/MEM ALU result (driven as 10). Bit 1 overrides bit 0.
- Load-use: hazard = ex_valid & ex_ctrl.mem_read & ex_rd != 0 & (ex_rd == id_rs1 | ex_rd == id_rs2) & id_valid. stall_o = hazard & ~flush.
- Next-state priority per clock: flush > hazard > normal load.
  - flush or hazard: insert bubble — ex_valid=0, ex_ctrl=0, ex_fwd_a/b=00; data fields don't-care (implementation loads zeros).
  - normal: load all ID fields; ex_valid = id_valid.
- Forward select computed from ID indices at load time (per operand N):
  - 10 if ex_valid & ex_ctrl.reg_write & ex_rd != 0 & ex_rd == id_rsN (instruction now in EX will be in EX/MEM).
  - else 01 if mem_reg_write & mem_rd != 0 & mem_rd == id_rsN (will be in MEM/WB).
  - else 00.
- WB bypass: if wb_reg_write & wb_rd != 0 & wb_rd == id_rsN, ex_rsN_data captures wb_data instead of id_rsN_data. Applies independently of select code.
- x0 never forwarded or bypassed.

## Timing

- Latency: 1 cycle ID -> EX for all fields and select codes.
- stall_o is combinational, same cycle as hazard; exactly one bubble per load-use; next cycle hazard clears (load moved to MEM) and instruction loads with select 01.
- Reset (async, immediate): all ex_* outputs 0, ex_fwd_a/b = 00, stall_o = 0 once ex_valid = 0. Reset mid-stall drops the bubble; no state survives.
- flush and hazard in same cycle: bubble, stall_o = 0.
- id_valid=0: loads as bubble-equivalent (ex_valid=0), select computed but irrelevant.

## Configuration

- ID_EX_FWD_EN defined: forwarding as above.
- Undefined: ex_fwd_a/b tied to 00; hazard extended to any RAW against EX (ex_valid & reg_write) or EX/MEM (mem_reg_write), rd != 0 — stall until clear. WB bypass retained.

## Structure

- Package pipe_pkg: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; ctrl-field bit-position constants; ctrl_t packed typedef.
- One sub-module: fwd_unit (combinational select and hazard logic), instanced by id_ex_stage; register process in the top.

## Test plan

- Back-to-back ALU: add x5 then sub x6,x5,x1 -> second ex_fwd_a=10, no stall.
- Distance two: add x5; nop; or x7,x5,x5 -> ex_fwd_a=01, ex_fwd_b=01.
- Load-use: lw x5; add x6,x5,x2 -> stall_o=1 one cycle, one bubble (ex_valid=0), then ex_fwd_a=01.
- WB bypass: wb_rd=x9, wb_data=0xDEADBEEF, id_rs2=x9, id_rs2_data=0 -> ex_rs2_data=0xDEADBEEF.
- x0 and flush: rd=x0 producer -> select 00; flush during load-use -> bubble, stall_o=0.
- Reset asserted mid-stall -> all outputs 0 immediately; ID_EX_FWD_EN undefined build: dependent add stalls 2 cycles, selects 00.
